// File: rtl/score_pkg.sv
// score_pkg: shared FSM state type and saturating arithmetic helpers for the score keeper.
package score_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, SCORE, DONE} state_e;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (33'd1 << w) - 33'd1;
        return (s > mx) ? mx[31:0] : s[31:0];
    endfunction

    function automatic logic [31:0] floor_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a - b : 32'd0;
    endfunction

endpackage

// File: rtl/score_accum.sv
// score_accum: one player's total; saturating add or floored subtract of a delta.
module score_accum
    import score_pkg::*;
#(
    parameter int SCORE_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               neg,
    input  logic [SCORE_W-1:0] delta,
    output logic [SCORE_W-1:0] total
);

    logic [SCORE_W-1:0] total_q, total_d;

    always_comb begin
        total_d = total_q;
        if (clr)
            total_d = '0;
        else if (en)
            total_d = neg ? SCORE_W'(floor_sub(32'(total_q), 32'(delta)))
                          : SCORE_W'(sat_add(32'(total_q), 32'(delta), SCORE_W));
    end

    always_ff @(posedge clk) begin
        if (rst)
            total_q <= '0;
        else
            total_q <= total_d;
    end

    assign total = total_q;

endmodule

// File: rtl/multi_score_file.sv
// multi_score_file: N-player quiz score keeper; turns answers into deltas, counts rounds
// and tracks the leader.
module multi_score_file
    import score_pkg::*;
#(
    parameter int N_PLAYERS   = 4,
    parameter int SCORE_W     = 9,
    parameter int COUNT_W     = 8,
    parameter int N_ROUNDS    = 8,
    parameter int BASE_PTS    = 10,
    parameter int PENALTY     = 5,
    parameter int BONUS_SHIFT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [COUNT_W-1:0]             count,
    input  logic                           ans_valid,
    input  logic [$clog2(N_PLAYERS)-1:0]   ans_player,
    input  logic                           ans_right,
    output logic [SCORE_W-1:0]             delta_pts,
    output logic                           delta_neg,
    output logic [N_PLAYERS*SCORE_W-1:0]   total_score,
    output logic [7:0]                     round_num,
    output logic [$clog2(N_PLAYERS)-1:0]   leader,
    output logic                           tie,
    output logic                           finish
);

    localparam int PW = $clog2(N_PLAYERS);

    state_e             state_q, state_d;
    logic [7:0]         round_q, round_d;
    logic [SCORE_W-1:0] dpts_q, dpts_d;
    logic               dneg_q, dneg_d;
    logic [PW-1:0]      tgt_q, tgt_d;
    logic               hit_q, hit_d;
    logic [PW-1:0]      lead_q, lead_d;
    logic               tie_q, tie_d;
    logic               clr;
    logic               in_range;
    logic [SCORE_W-1:0] bonus_pts, pen_pts, best;
    logic [SCORE_W-1:0] tot [N_PLAYERS];

    assign in_range  = 32'(ans_player) < N_PLAYERS;
    assign bonus_pts = SCORE_W'(sat_add(32'(BASE_PTS), 32'(count) >> BONUS_SHIFT, SCORE_W));
    assign pen_pts   = SCORE_W'(sat_add(32'(PENALTY), 32'd0, SCORE_W));

    // hit_q distinguishes a scored answer from a timeout, which updates no total
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        dpts_d  = dpts_q;
        dneg_d  = dneg_q;
        tgt_d   = tgt_q;
        hit_d   = hit_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ROUND;
                round_d = '0;
                dpts_d  = '0;
                dneg_d  = 1'b0;
                clr     = 1'b1;
            end
            ROUND: if (ans_valid && in_range) begin
                state_d = SCORE;
                tgt_d   = ans_player;
                hit_d   = 1'b1;
                dpts_d  = ans_right ? bonus_pts : pen_pts;
                dneg_d  = !ans_right;
            end else if (count == '0) begin
                state_d = SCORE;
                hit_d   = 1'b0;
                dpts_d  = '0;
                dneg_d  = 1'b0;
            end
            SCORE: begin
                round_d = round_q + 8'd1;
                state_d = (round_d == 8'(N_ROUNDS)) ? DONE : ROUND;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_acc
        score_accum #(.SCORE_W(SCORE_W)) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en    (state_q == SCORE && hit_q && tgt_q == PW'(g)),
            .neg   (dneg_q),
            .delta (dpts_q),
            .total (tot[g])
        );
        assign total_score[g*SCORE_W +: SCORE_W] = tot[g];
    end

    // strict '>' keeps the lowest index on equal totals
    always_comb begin
        best   = tot[0];
        lead_d = '0;
        tie_d  = 1'b0;
        for (int i = 1; i < N_PLAYERS; i++)
            if (tot[i] > best) begin
                best   = tot[i];
                lead_d = PW'(i);
            end
        for (int i = 0; i < N_PLAYERS; i++)
            if (tot[i] == best && PW'(i) != lead_d)
                tie_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            dpts_q  <= '0;
            dneg_q  <= 1'b0;
            tgt_q   <= '0;
            hit_q   <= 1'b0;
            lead_q  <= '0;
            tie_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            dpts_q  <= dpts_d;
            dneg_q  <= dneg_d;
            tgt_q   <= tgt_d;
            hit_q   <= hit_d;
            lead_q  <= lead_d;
            tie_q   <= tie_d;
        end
    end

    assign delta_pts = dpts_q;
    assign delta_neg = dneg_q;
    assign round_num = round_q;
    assign leader    = lead_q;
    assign tie       = tie_q;
    assign finish    = state_q == DONE;

endmodule

// File: tb/tb_multi_score_file.sv
// tb_multi_score_file: scoreboard bench; stimulus queues expected per-round results,
// monitors pop them whenever a DUT's round_num advances.
module tb_multi_score_file;

    typedef struct {
        logic [7:0]  rnd;
        logic [71:0] tot;
        logic [8:0]  dp;
        logic        dn;
        logic        fin;
        logic [2:0]  ld;
        logic        tie;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        start [2];
    logic [7:0]  cnt   [2];
    logic        av    [2];
    logic [2:0]  ap    [2];
    logic        ar    [2];
    logic [8:0]  dp    [2];
    logic        dn    [2];
    logic [7:0]  rnd   [2];
    logic        tie   [2];
    logic        fin   [2];
    logic [71:0] tot   [2];
    logic [2:0]  ld    [2];
    logic [35:0] tot_a;
    logic [53:0] tot_b;
    logic [1:0]  ld_a;
    logic [2:0]  ld_b;

    assign tot[0] = {36'd0, tot_a};
    assign tot[1] = {18'd0, tot_b};
    assign ld[0]  = {1'b0, ld_a};
    assign ld[1]  = ld_b;

    multi_score_file #(.N_PLAYERS(4), .SCORE_W(9), .COUNT_W(8), .N_ROUNDS(3),
                       .BASE_PTS(10), .PENALTY(5), .BONUS_SHIFT(4)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .count(cnt[0]), .ans_valid(av[0]),
        .ans_player(ap[0][1:0]), .ans_right(ar[0]), .delta_pts(dp[0]), .delta_neg(dn[0]),
        .total_score(tot_a), .round_num(rnd[0]), .leader(ld_a), .tie(tie[0]), .finish(fin[0]));

    multi_score_file #(.N_PLAYERS(6), .SCORE_W(9), .COUNT_W(8), .N_ROUNDS(255),
                       .BASE_PTS(10), .PENALTY(5), .BONUS_SHIFT(4)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .count(cnt[1]), .ans_valid(av[1]),
        .ans_player(ap[1]), .ans_right(ar[1]), .delta_pts(dp[1]), .delta_neg(dn[1]),
        .total_score(tot_b), .round_num(rnd[1]), .leader(ld_b), .tie(tie[1]), .finish(fin[1]));

    exp_t q0[$];
    exp_t q1[$];
    int vec  = 0;
    int miss = 0;

    function automatic logic [71:0] pk(input int t0, input int t1, input int t2,
                                       input int t3, input int t4, input int t5);
        return {18'd0, 9'(t5), 9'(t4), 9'(t3), 9'(t2), 9'(t1), 9'(t0)};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int r, input logic [71:0] t, input int p,
                        input logic n, input logic f, input int l, input logic ti);
        exp_t e;
        e.rnd = 8'(r); e.tot = t; e.dp = 9'(p); e.dn = n; e.fin = f; e.ld = 3'(l); e.tie = ti;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic mon(input int d);
        logic [7:0] prev;
        exp_t e;
        prev = 8'd0;
        forever begin
            @(negedge clk);
            if (rnd[d] == prev + 8'd1) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    vec++;
                    miss++;
                    $display("FAIL dut%0d unexpected round: got %0d, want none", d, rnd[d]);
                end else begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    chk($sformatf("dut%0d r%0d round_num", d, e.rnd), rnd[d], e.rnd);
                    chk($sformatf("dut%0d r%0d totals", d, e.rnd), tot[d], e.tot);
                    chk($sformatf("dut%0d r%0d delta_pts", d, e.rnd), dp[d], e.dp);
                    chk($sformatf("dut%0d r%0d delta_neg", d, e.rnd), dn[d], e.dn);
                    chk($sformatf("dut%0d r%0d finish", d, e.rnd), fin[d], e.fin);
                    @(negedge clk);
                    chk($sformatf("dut%0d r%0d leader", d, e.rnd), ld[d], e.ld);
                    chk($sformatf("dut%0d r%0d tie", d, e.rnd), tie[d], e.tie);
                end
            end
            prev = rnd[d];
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ans(input int d, input int p, input logic r, input int c);
        av[d] = 1'b1; ap[d] = 3'(p); ar[d] = r; cnt[d] = 8'(c);
        tick();
        av[d] = 1'b0; cnt[d] = 8'd100;
        tick();
    endtask

    task automatic tmo(input int d);
        cnt[d] = 8'd0;
        tick();
        cnt[d] = 8'd100;
        tick();
    endtask

    task automatic go(input int d);
        rst[d] = 1'b1;
        tick();
        rst[d] = 1'b0;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; cnt[i] = 8'd100; av[i] = 1'b0; ap[i] = 3'd0; ar[i] = 1'b0;
        end
        tick();
        tick();
        rst[0] = 1'b0;
        av[0] = 1'b1; ap[0] = 3'd1; ar[0] = 1'b1;
        tick();
        av[0] = 1'b0;
        tick();
        chk("idle totals", tot[0], 72'd0);
        chk("idle round_num", rnd[0], 72'd0);
        chk("idle tie", tie[0], 72'd1);
        chk("idle leader", ld[0], 72'd0);
        chk("idle finish", fin[0], 72'd0);
        chk("idle delta_pts", dp[0], 72'd0);

        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        push(0, 1, pk(0, 22, 0, 0, 0, 0), 22, 1'b0, 1'b0, 1, 1'b0);
        ans(0, 1, 1'b1, 200);
        push(0, 2, pk(0, 22, 0, 0, 0, 0), 5, 1'b1, 1'b0, 1, 1'b0);
        ans(0, 2, 1'b0, 100);
        push(0, 3, pk(0, 17, 0, 0, 0, 0), 5, 1'b1, 1'b1, 1, 1'b0);
        ans(0, 1, 1'b0, 100);
        av[0] = 1'b1; ap[0] = 3'd3; ar[0] = 1'b1;
        tick();
        av[0] = 1'b0;
        tick();
        chk("done frozen totals", tot[0], pk(0, 17, 0, 0, 0, 0));
        chk("done round_num", rnd[0], 72'd3);
        chk("done finish held", fin[0], 72'd1);

        go(0);
        push(0, 1, 72'd0, 0, 1'b0, 1'b0, 0, 1'b1);
        tmo(0);
        push(0, 2, 72'd0, 0, 1'b0, 1'b0, 0, 1'b1);
        tmo(0);
        push(0, 3, 72'd0, 0, 1'b0, 1'b1, 0, 1'b1);
        tmo(0);
        av[0] = 1'b1; ap[0] = 3'd0; ar[0] = 1'b1;
        tick();
        av[0] = 1'b0;
        tick();
        chk("timeout totals after late answer", tot[0], 72'd0);
        chk("timeout round_num", rnd[0], 72'd3);

        go(0);
        push(0, 1, pk(0, 0, 0, 10, 0, 0), 10, 1'b0, 1'b0, 3, 1'b0);
        ans(0, 3, 1'b1, 0);

        go(1);
        for (int k = 1; k <= 25; k++) begin
            push(1, k, pk((25 * k > 511) ? 511 : 25 * k, 0, 0, 0, 0, 0), 25, 1'b0, 1'b0, 0, 1'b0);
            ans(1, 0, 1'b1, 255);
        end
        for (int j = 1; j <= 21; j++) begin
            push(1, 25 + j, pk(511, 0, (25 * j > 511) ? 511 : 25 * j, 0, 0, 0), 25, 1'b0, 1'b0, 0, j == 21);
            ans(1, 2, 1'b1, 255);
        end
        av[1] = 1'b1; ap[1] = 3'd6; ar[1] = 1'b1;
        tick();
        ap[1] = 3'd7;
        tick();
        av[1] = 1'b0;
        tick();
        chk("drop out-of-range round_num", rnd[1], 72'd46);
        chk("drop out-of-range totals", tot[1], pk(511, 0, 511, 0, 0, 0));
        push(1, 47, pk(511, 0, 511, 0, 0, 16), 16, 1'b0, 1'b0, 0, 1'b1);
        ans(1, 5, 1'b1, 100);

        push(1, 48, pk(511, 0, 511, 16, 0, 16), 16, 1'b0, 1'b0, 0, 1'b1);
        av[1] = 1'b1; ap[1] = 3'd3; ar[1] = 1'b1;
        tick();
        ap[1] = 3'd4;
        tick();
        av[1] = 1'b0;
        tick();
        chk("drop in SCORE totals", tot[1], pk(511, 0, 511, 16, 0, 16));
        chk("drop in SCORE round_num", rnd[1], 72'd48);

        av[1] = 1'b1; ap[1] = 3'd1; ar[1] = 1'b1;
        tick();
        av[1] = 1'b0; rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("rst in SCORE round_num", rnd[1], 72'd0);
        chk("rst in SCORE totals", tot[1], 72'd0);
        chk("rst in SCORE delta_pts", dp[1], 72'd0);
        chk("rst in SCORE finish", fin[1], 72'd0);
        av[1] = 1'b1; ap[1] = 3'd1;
        tick();
        av[1] = 1'b0;
        tick();
        tick();
        chk("post-rst idle round_num", rnd[1], 72'd0);
        chk("post-rst idle totals", tot[1], 72'd0);
        chk("post-rst leader", ld[1], 72'd0);
        chk("post-rst tie", tie[1], 72'd1);

        tick();
        tick();
        chk("dut0 scoreboard drained", q0.size(), 72'd0);
        chk("dut1 scoreboard drained", q1.size(), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
